imem_fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer in front of the combinational-read instruction memory.

---
 rtl/imem_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the fetch PC, reads the combinational IMEM and
// queues {pc, inst} pairs in a small prefetch FIFO for decode.
module imem_fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IMEM_WORDS = 2048
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_inst_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            fault_o,
    output logic [1:0]      state_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [XLEN-3:0] LP_LIMIT = (XLEN-2)'(IMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fifo_inst [DEPTH];
    logic [XLEN-1:0] r_fifo_pc   [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;
    logic            w_pop;
    logic            w_push;
    logic            w_in_range;
    logic            w_misalign;
    logic            w_has_room;

    assign w_in_range   = r_pc[XLEN-1:2] < LP_LIMIT;
    assign w_misalign   = redirect_pc_i[1:0] != 2'b00;
    assign w_has_room   = (r_count < LP_DEPTH) | w_pop;
    assign inst_valid_o = r_count != '0;
    assign w_pop        = inst_valid_o & inst_ready_i;
    assign w_push       = (r_state == S_RUN) & ~redirect_i & ~halt_i
                        & w_in_range & w_has_room;

    assign imem_addr_o = r_pc;
    assign inst_o      = inst_valid_o ? r_fifo_inst[r_rd] : '0;
    assign inst_pc_o   = inst_valid_o ? r_fifo_pc[r_rd] : '0;
    assign fault_o     = r_state == S_FAULT;
    assign state_o     = r_state;

    // A misaligned redirect faults from any state; halt beats start.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_i && w_misalign) begin
            w_state_nxt = S_FAULT;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i && !halt_i) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (halt_i) w_state_nxt = S_HALTED;
                    else if (!redirect_i && !w_in_range)
                        w_state_nxt = S_FAULT;
                end
                S_HALTED: begin
                    if (start_i && !halt_i) w_state_nxt = S_RUN;
                end
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i)  r_pc <= redirect_pc_i;
            else if (w_push) r_pc <= r_pc + XLEN'(4);
            if (redirect_i) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_pop)  r_rd <= r_rd + 1'b1;
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (w_pop && !w_push)
                    r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_inst[r_wr] <= imem_inst_i;
            r_fifo_pc[r_wr]   <= r_pc;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch sequencer.
module tb_imem_fetch_ctrl;
    localparam int DEPTH = 2;
    localparam int IW    = 2048;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fault_o;
    logic [1:0]  state_o;

    int ncmp = 0;
    int nfail = 0;

    imem_fetch_ctrl #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .IMEM_WORDS(IW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    assign imem_inst_i = imem_fn(imem_addr_o);

    // Reference model: state number, fetch pc, queue of {pc, inst}
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];

    logic [99:0] obs;
    assign obs = {state_o, fault_o, inst_valid_o, inst_pc_o, inst_o, imem_addr_o};

    function automatic logic [99:0] expv();
        logic [63:0] h;
        logic [1:0]  s;
        h = (m_q.size() != 0) ? m_q[0] : 64'd0;
        s = 2'(m_state);
        return {s, (m_state == 3), (m_q.size() != 0), h, m_pc};
    endfunction

    task automatic cyc();
        bit pop, push, inr;
        int ns;
        pop  = (m_q.size() != 0) && inst_ready_i;
        inr  = (m_pc >> 2) < 32'(IW);
        push = (m_state == 1) && !redirect_i && !halt_i && inr
             && ((m_q.size() < DEPTH) || pop);
        ns = m_state;
        if (redirect_i && redirect_pc_i[1:0] != 2'b00) ns = 3;
        else if (m_state == 0 || m_state == 2) begin
            if (start_i && !halt_i) ns = 1;
        end else if (m_state == 1) begin
            if (halt_i) ns = 2;
            else if (!redirect_i && !inr) ns = 3;
        end
        if (pop) void'(m_q.pop_front());
        if (redirect_i) m_q.delete();
        else if (push) m_q.push_back({m_pc, imem_fn(m_pc)});
        if (redirect_i) m_pc = redirect_pc_i;
        else if (push) m_pc = m_pc + 32'd4;
        @(posedge clk_i);
        #1;
        m_state = ns;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 0; halt_i = 0; redirect_i = 0;
        redirect_pc_i = '0; inst_ready_i = 0;
        m_state = 0; m_pc = '0; m_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++;
        if (obs !== expv()) begin
            nfail++; $display("FAIL reset_state got %h exp %h", obs, expv());
        end
        start_i = 1; cyc(); start_i = 0;
        cyc(); cyc();
        ncmp++;
        if (inst_valid_o !== 1'b1 || state_o !== 2'd1) begin
            nfail++; $display("FAIL reset_pre got v%b s%0d exp v1 s1", inst_valid_o, state_o);
        end
        #2; rst_i = 1'b1; #1;
        ncmp++;
        if ({state_o, inst_valid_o, fault_o, imem_addr_o, inst_o, inst_pc_o} !== 68'd0) begin
            nfail++; $display("FAIL reset_async got s%0d v%b a%h exp all zero",
                              state_o, inst_valid_o, imem_addr_o);
        end
        m_state = 0; m_pc = '0; m_q.delete();
        @(posedge clk_i); #1; rst_i = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        inst_ready_i = 1; start_i = 1;
        cyc();
        start_i = 0;
        ncmp++;
        if (state_o !== 2'd1 || inst_valid_o !== 1'b0) begin
            nfail++; $display("FAIL stream_start got s%0d v%b exp s1 v0", state_o, inst_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            ncmp++;
            if (inst_pc_o !== 32'(4*i) || inst_o !== imem_fn(32'(4*i)) || !inst_valid_o) begin
                nfail++; $display("FAIL stream_word%0d got pc %h inst %h exp pc %h inst %h",
                                  i, inst_pc_o, inst_o, 32'(4*i), imem_fn(32'(4*i)));
            end
            ncmp++;
            if (obs !== expv()) begin
                nfail++; $display("FAIL stream_model%0d got %h exp %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_i = 1; cyc(); start_i = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ncmp++;
            if (obs !== expv()) begin
                nfail++; $display("FAIL bp_hold%0d got %h exp %h", i, obs, expv());
            end
        end
        ncmp++;
        if (imem_addr_o !== 32'(4*DEPTH) || inst_pc_o !== 32'd0) begin
            nfail++; $display("FAIL bp_sat got addr %h head %h exp addr %h head 0",
                              imem_addr_o, inst_pc_o, 32'(4*DEPTH));
        end
        inst_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            ncmp++;
            if (inst_pc_o !== 32'(4*i) || inst_valid_o !== 1'b1) begin
                nfail++; $display("FAIL bp_order%0d got pc %h v%b exp pc %h v1",
                                  i, inst_pc_o, inst_valid_o, 32'(4*i));
            end
            cyc();
        end
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset();
        start_i = 1; cyc(); start_i = 0;
        cyc();
        inst_ready_i = 1; cyc(); cyc();
        inst_ready_i = 0; cyc(); cyc();
        ncmp++;
        if (inst_pc_o !== 32'h8 || imem_addr_o !== 32'h10 || obs !== expv()) begin
            nfail++; $display("FAIL redir_pre got head %h addr %h exp head 8 addr 10",
                              inst_pc_o, imem_addr_o);
        end
        redirect_i = 1; redirect_pc_i = 32'h40; inst_ready_i = 1;
        cyc();
        redirect_i = 0;
        ncmp++;
        if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin
            nfail++; $display("FAIL redir_flush got v%b addr %h exp v0 addr 40",
                              inst_valid_o, imem_addr_o);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (inst_valid_o && !seen) begin
                seen = 1;
                ncmp++;
                if (inst_pc_o !== 32'h40) begin
                    nfail++; $display("FAIL redir_first got %h exp 40", inst_pc_o);
                end
            end
            ncmp++;
            if (inst_valid_o && (inst_pc_o == 32'h8 || inst_pc_o == 32'hC)) begin
                nfail++; $display("FAIL redir_stale got %h exp none of 8/C", inst_pc_o);
            end
        end
        ncmp++;
        if (!seen) begin
            nfail++; $display("FAIL redir_none got no valid exp pc 40");
        end
    endtask

    task automatic test_misalign();
        do_reset();
        start_i = 1; inst_ready_i = 1; cyc(); start_i = 0;
        cyc(); cyc();
        redirect_i = 1; redirect_pc_i = 32'h42;
        cyc();
        redirect_i = 0;
        ncmp++;
        if (state_o !== 2'd3 || fault_o !== 1'b1 || imem_addr_o !== 32'h42) begin
            nfail++; $display("FAIL mis_fault got s%0d f%b a%h exp s3 f1 a42",
                              state_o, fault_o, imem_addr_o);
        end
        start_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ncmp++;
            if (inst_valid_o !== 1'b0 || obs !== expv()) begin
                nfail++; $display("FAIL mis_stuck%0d got %h exp %h", i, obs, expv());
            end
        end
        do_reset();
        ncmp++;
        if (state_o !== 2'd0 || fault_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            nfail++; $display("FAIL mis_clear got s%0d f%b exp s0 f0", state_o, fault_o);
        end
    endtask

    task automatic test_range();
        do_reset();
        redirect_i = 1; redirect_pc_i = 32'(4*IW - 8);
        cyc();
        redirect_i = 0;
        ncmp++;
        if (state_o !== 2'd0 || imem_addr_o !== 32'(4*IW - 8)) begin
            nfail++; $display("FAIL range_idle got s%0d a%h exp s0 a%h",
                              state_o, imem_addr_o, 32'(4*IW - 8));
        end
        start_i = 1; inst_ready_i = 1; cyc(); start_i = 0;
        cyc();
        ncmp++;
        if (inst_pc_o !== 32'(4*IW - 8) || obs !== expv()) begin
            nfail++; $display("FAIL range_w0 got %h exp %h", inst_pc_o, 32'(4*IW - 8));
        end
        cyc();
        ncmp++;
        if (inst_pc_o !== 32'(4*IW - 4) || inst_valid_o !== 1'b1) begin
            nfail++; $display("FAIL range_last got %h exp %h", inst_pc_o, 32'(4*IW - 4));
        end
        cyc();
        ncmp++;
        if (state_o !== 2'd3 || fault_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            nfail++; $display("FAIL range_fault got s%0d f%b v%b exp s3 f1 v0",
                              state_o, fault_o, inst_valid_o);
        end
    endtask

    task automatic test_halt();
        do_reset();
        start_i = 1; cyc(); start_i = 0;
        cyc(); cyc();
        halt_i = 1; start_i = 1;
        cyc();
        halt_i = 0; start_i = 0;
        ncmp++;
        if (state_o !== 2'd2 || imem_addr_o !== 32'h8) begin
            nfail++; $display("FAIL halt_enter got s%0d a%h exp s2 a8", state_o, imem_addr_o);
        end
        inst_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            ncmp++;
            if (obs !== expv()) begin
                nfail++; $display("FAIL halt_drain%0d got %h exp %h", i, obs, expv());
            end
        end
        ncmp++;
        if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'h8) begin
            nfail++; $display("FAIL halt_empty got v%b a%h exp v0 a8", inst_valid_o, imem_addr_o);
        end
        start_i = 1; cyc(); start_i = 0;
        ncmp++;
        if (state_o !== 2'd1) begin
            nfail++; $display("FAIL halt_resume got s%0d exp s1", state_o);
        end
        cyc();
        ncmp++;
        if (inst_pc_o !== 32'h8 || inst_valid_o !== 1'b1) begin
            nfail++; $display("FAIL halt_next got %h exp 8", inst_pc_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        start_i = 1; cyc();
        for (int i = 0; i < 400; i++) begin
            inst_ready_i  = ($urandom_range(0, 9) < 7);
            halt_i        = ($urandom_range(0, 19) == 0);
            start_i       = ($urandom_range(0, 9) == 0);
            redirect_i    = ($urandom_range(0, 24) == 0);
            redirect_pc_i = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            cyc();
            ncmp++;
            if (obs !== expv()) begin
                nfail++; $display("FAIL random%0d got %h exp %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_range();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
